wb_sram_slave: RTL

Wishbone B3 slave (responder) wrapping an on-chip byte-enabled SRAM. It sits on the single downstream bus driven by the 3-way master arbiter, on the slave side of that same interface. It serves classic single cycles, constant-address bursts and linear incrementing bursts. Acks are registered, with a programmable number of initial wait states.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/byte_ram.sv | 46 ++++
 rtl/wb_sram_slave.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes, bus widths and slave state encoding.
// No logic; imported by the slave and its testbench.
// Not applicable: constants only.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_BURST = 2'd3
    } slave_state_t;

    function automatic logic cti_is_burst(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INCR);
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port-per-direction SRAM, 32-bit words with per-byte write enables.
// Latency: read data registered, valid one cycle after rd_adr is presented.
// Backpressure: none; a write on the same edge as a read of that word is forwarded.
module byte_ram
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  core_clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_adr,
    output logic [WB_DATA_W-1:0]  rd_dat,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_adr,
    input  logic [WB_DATA_W-1:0]  wr_dat,
    input  logic [WB_SEL_W-1:0]   wr_sel
);

    logic [WB_DATA_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (wr_sel[b]) begin
                    mem[wr_adr][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    // Write-first per lane so a read issued on the committing edge sees new bytes.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            rd_dat <= '0;
        end else begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (wr_en && wr_sel[b] && (wr_adr == rd_adr)) begin
                    rd_dat[8*b +: 8] <= wr_dat[8*b +: 8];
                end else begin
                    rd_dat[8*b +: 8] <= mem[rd_adr][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B3 slave over byte_ram: classic, constant and incrementing bursts.
// Latency: first ack WAIT_STATES+1 cycles after request, then one beat per cycle.
// Backpressure: stb_i low stalls a burst; ack is gated by cyc_i & stb_i.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [31:0]          adr_i,
    input  logic [WB_DATA_W-1:0] dat_i,
    output logic [WB_DATA_W-1:0] dat_o,
    input  logic [WB_SEL_W-1:0]  sel_i,
    input  logic                 we_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic [2:0]           cti_i,
    input  logic [1:0]           bte_i,
    output logic                 ack_o
);

    slave_state_t          state, state_nxt;
    logic [2:0]            wcnt;
    logic [2:0]            wcnt_dec;
    logic [ADDR_WIDTH-1:0] badr, badr_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  req;
    logic                  ack_r;
    logic                  wr_en;
    slave_state_t          serve_state;

    // Only linear bursts exist, so bte_i and the out-of-range address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, bte_i, adr_i[31:ADDR_WIDTH+2], adr_i[1:0]};

    assign req         = cyc_i & stb_i;
    assign idx         = adr_i[ADDR_WIDTH+1:2];
    assign wcnt_dec    = wcnt - 3'd1;
    assign serve_state = cti_is_burst(cti_i) ? ST_BURST : ST_ACK;
    assign ack_o       = ack_r & req;
    assign wr_en       = ack_o & we_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES != 0) ? ST_WAIT : serve_state;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (req && (wcnt_dec == 3'd0)) begin
                    state_nxt = serve_state;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            ST_BURST: begin
                if (!cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (ack_o && (cti_i == CTI_EOB)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // badr_nxt doubles as the RAM read address, which gives the burst its one-word prefetch.
    always_comb begin
        ack_r    = (state == ST_ACK) || (state == ST_BURST);
        badr_nxt = badr;
        if ((state == ST_IDLE) && req) begin
            badr_nxt = idx;
        end else if ((state == ST_BURST) && ack_o && (cti_i == CTI_INCR)) begin
            badr_nxt = badr + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wcnt <= 3'd0;
            badr <= '0;
        end else begin
            badr <= badr_nxt;
            if ((state == ST_IDLE) && req) begin
                wcnt <= 3'(WAIT_STATES);
            end else if ((state == ST_WAIT) && req) begin
                wcnt <= wcnt_dec;
            end
        end
    end

    byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .core_clk (clock_i),
        .rst      (reset_i),
        .rd_adr   (badr_nxt),
        .rd_dat   (dat_o),
        .wr_en    (wr_en),
        .wr_adr   (badr),
        .wr_dat   (dat_i),
        .wr_sel   (sel_i)
    );

endmodule
